// File: rtl/draw_pkg.sv
// Shared definitions for the screen draw sequencer: screen codes, pixel field widths and FSM states.
package draw_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COL_W    = 3;
    localparam int N_SRC    = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [1:0] SCR_SPLASH  = 2'd0;
    localparam logic [1:0] SCR_VICTORY = 2'd1;
    localparam logic [1:0] SCR_DEATH   = 2'd2;
    localparam logic [1:0] SCR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_DRAW  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_FIN   = 3'd4,
        ST_ABORT = 3'd5
    } state_t;

    function automatic logic [N_SRC-1:0] screen_onehot(input logic [1:0] scr);
        logic [N_SRC-1:0] oh;
        case (scr)
            SCR_SPLASH:  oh = 3'b001;
            SCR_VICTORY: oh = 3'b010;
            SCR_DEATH:   oh = 3'b100;
            default:     oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/coord_delay_pipe.sv
// DEPTH-stage register pipe of {x, y, valid} that re-times drawer coordinates to the image RAM latency.
module coord_delay_pipe #(
    parameter int DEPTH = 1,
    parameter int X_W   = 8,
    parameter int Y_W   = 7
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           clear,
    input  logic           shift,
    input  logic           bubble,
    input  logic [X_W-1:0] in_x,
    input  logic [Y_W-1:0] in_y,
    input  logic           in_valid,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y,
    output logic           out_valid
);

    logic [X_W-1:0]   x_r [DEPTH];
    logic [Y_W-1:0]   y_r [DEPTH];
    logic [DEPTH-1:0] valid_r;

    // A bubble repeats the stage-0 coordinate so the drained pipe output holds its last value
    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                x_r[i] <= '0;
                y_r[i] <= '0;
            end
            valid_r <= '0;
        end else if (shift) begin
            if (bubble) begin
                x_r[0]     <= x_r[0];
                y_r[0]     <= y_r[0];
                valid_r[0] <= 1'b0;
            end else begin
                x_r[0]     <= in_x;
                y_r[0]     <= in_y;
                valid_r[0] <= in_valid;
            end
            for (int i = 1; i < DEPTH; i++) begin
                x_r[i]     <= x_r[i-1];
                y_r[i]     <= y_r[i-1];
                valid_r[i] <= valid_r[i-1];
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_x     = x_r[DEPTH-1];
    assign out_y     = y_r[DEPTH-1];
    assign out_valid = valid_r[DEPTH-1];

endmodule

// File: rtl/screen_draw_ctrl.sv
// Sequencer and pixel mux between the splash/victory/death drawers and the VGA adapter write port.
// Clears and enables the selected drawer, re-times its coordinates, and reports busy/done/err.
module screen_draw_ctrl
    import draw_pkg::*;
#(
    parameter int RAM_LATENCY   = 1,
    parameter int MAX_CYCLES    = 20000,
    parameter int SCREEN_PIXELS = 19200
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req,
    input  logic [1:0]       req_screen,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       src_enable,
    output logic [2:0]       src_clear_n,
    input  logic [23:0]      src_x,
    input  logic [20:0]      src_y,
    input  logic [8:0]       src_col,
    input  logic [2:0]       src_done,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic [COL_W-1:0] vga_col,
    output logic             vga_plot
);

    localparam int              WD_W       = $clog2(SCREEN_PIXELS + 1);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(MAX_CYCLES - 1);
    localparam logic [1:0]      FLUSH_LAST = 2'(RAM_LATENCY - 1);

    state_t            state_r, state_s;
    logic [1:0]        sel_r, sel_s;
    logic [WD_W-1:0]   wd_r, wd_s;
    logic [1:0]        flush_cnt_r, flush_cnt_s;
    logic              busy_r, busy_s, done_r, done_s, err_r, err_s;
    logic              active_r, active_s;
    logic [2:0]        src_enable_r, src_enable_s;
    logic [2:0]        src_clear_n_r, src_clear_n_s;
    logic [COL_W-1:0]  col_hold_r;

    logic [X_W-1:0]    x_sel_s, pipe_x_s;
    logic [Y_W-1:0]    y_sel_s, pipe_y_s;
    logic [COL_W-1:0]  col_sel_s;
    logic              done_sel_s, pipe_valid_s;
    logic              pipe_clear_s, pipe_shift_s, pipe_bubble_s, pipe_in_valid_s;

    // Select the latched drawer's stream; other drawers never reach the outputs
    always_comb begin
        x_sel_s    = 8'd0;
        y_sel_s    = 7'd0;
        col_sel_s  = 3'd0;
        done_sel_s = 1'b0;
        case (sel_r)
            SCR_SPLASH: begin
                x_sel_s    = src_x[7:0];
                y_sel_s    = src_y[6:0];
                col_sel_s  = src_col[2:0];
                done_sel_s = src_done[0];
            end
            SCR_VICTORY: begin
                x_sel_s    = src_x[15:8];
                y_sel_s    = src_y[13:7];
                col_sel_s  = src_col[5:3];
                done_sel_s = src_done[1];
            end
            SCR_DEATH: begin
                x_sel_s    = src_x[23:16];
                y_sel_s    = src_y[20:14];
                col_sel_s  = src_col[8:6];
                done_sel_s = src_done[2];
            end
            default: begin
                x_sel_s    = 8'd0;
                y_sel_s    = 7'd0;
                col_sel_s  = 3'd0;
                done_sel_s = 1'b0;
            end
        endcase
    end

    // Next-state logic; outputs are decoded from the next state so they register in step with it
    always_comb begin
        state_s     = state_r;
        sel_s       = sel_r;
        wd_s        = wd_r;
        flush_cnt_s = flush_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req && (req_screen != SCR_INVALID)) begin
                    sel_s   = req_screen;
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                wd_s    = '0;
                state_s = ST_DRAW;
            end
            ST_DRAW: begin
                wd_s        = wd_r + 1'b1;
                flush_cnt_s = 2'd0;
                if (done_sel_s) begin
                    state_s = ST_FLUSH;
                end else if (wd_r == WD_LAST) begin
                    state_s = ST_ABORT;
                end else begin
                    state_s = ST_DRAW;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == FLUSH_LAST) begin
                    state_s = ST_FIN;
                end else begin
                    flush_cnt_s = flush_cnt_r + 2'd1;
                    state_s     = ST_FLUSH;
                end
            end
            ST_FIN:   state_s = ST_IDLE;
            ST_ABORT: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase

        busy_s        = (state_s != ST_IDLE);
        done_s        = (state_s == ST_FIN);
        err_s         = (state_s == ST_ABORT);
        active_s      = (state_s == ST_DRAW) || (state_s == ST_FLUSH);
        src_enable_s  = (state_s == ST_DRAW)  ? screen_onehot(sel_s) : 3'b000;
        src_clear_n_s = (state_s == ST_CLEAR) ? ~screen_onehot(sel_s) : 3'b111;
    end

    // State and registered handshake/drawer-control outputs; drawers stay cleared while reset is held
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            sel_r         <= 2'd0;
            wd_r          <= '0;
            flush_cnt_r   <= 2'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            active_r      <= 1'b0;
            src_enable_r  <= 3'b000;
            src_clear_n_r <= 3'b000;
            col_hold_r    <= 3'd0;
        end else begin
            state_r       <= state_s;
            sel_r         <= sel_s;
            wd_r          <= wd_s;
            flush_cnt_r   <= flush_cnt_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            err_r         <= err_s;
            active_r      <= active_s;
            src_enable_r  <= src_enable_s;
            src_clear_n_r <= src_clear_n_s;
            col_hold_r    <= active_r ? col_sel_s : col_hold_r;
        end
    end

    assign pipe_shift_s    = (state_r == ST_DRAW) || (state_r == ST_FLUSH);
    assign pipe_bubble_s   = (state_r == ST_FLUSH);
    assign pipe_clear_s    = (state_s == ST_ABORT);
    assign pipe_in_valid_s = ~done_sel_s;

    coord_delay_pipe #(
        .DEPTH (RAM_LATENCY),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (pipe_clear_s),
        .shift     (pipe_shift_s),
        .bubble    (pipe_bubble_s),
        .in_x      (x_sel_s),
        .in_y      (y_sel_s),
        .in_valid  (pipe_in_valid_s),
        .out_x     (pipe_x_s),
        .out_y     (pipe_y_s),
        .out_valid (pipe_valid_s)
    );

    // Colour arrives from the image RAM in the same cycle as the re-timed coordinate, so it is not re-registered
    assign vga_col     = active_r ? col_sel_s : col_hold_r;
    assign vga_x       = pipe_x_s;
    assign vga_y       = pipe_y_s;
    assign vga_plot    = pipe_valid_s;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign src_enable  = src_enable_r;
    assign src_clear_n = src_clear_n_r;

endmodule

// File: tb/tb_screen_draw_ctrl.sv
// Directed bench for screen_draw_ctrl with a raster drawer model: col = (x+y)%8 returned one cycle late.
module tb_screen_draw_ctrl;

    logic        clock;
    logic        reset_n;
    logic        req;
    logic [1:0]  req_screen;
    logic        busy, done, err;
    logic [2:0]  src_enable, src_clear_n, src_done;
    logic [23:0] src_x;
    logic [20:0] src_y;
    logic [8:0]  src_col;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_col;
    logic        vga_plot;

    int vectors = 0;
    int miscompares = 0;

    logic        junk, hang, force_done0;
    logic [31:0] junk_r;
    logic [14:0] idx   [3];
    logic [2:0]  col_q [3];

    int plot_cnt, pix_err, exp_idx, done_cnt, err_cnt, busy_cnt, en_cnt;
    logic [7:0] first_x, last_x;
    logic [6:0] first_y, last_y;

    screen_draw_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .req_screen  (req_screen),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .src_enable  (src_enable),
        .src_clear_n (src_clear_n),
        .src_x       (src_x),
        .src_y       (src_y),
        .src_col     (src_col),
        .src_done    (src_done),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_col     (vga_col),
        .vga_plot    (vga_plot)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [7:0] pix_x(input logic [14:0] i);
        if (i >= 15'd19200) return 8'd159;
        return 8'(i % 15'd160);
    endfunction

    function automatic logic [6:0] pix_y(input logic [14:0] i);
        if (i >= 15'd19200) return 7'd119;
        return 7'(i / 15'd160);
    endfunction

    // Drawer model: raster counter per drawer, colour lags its coordinate by one cycle
    always @(posedge clock) begin
        junk_r <= $urandom;
        for (int n = 0; n < 3; n++) begin
            if (!src_clear_n[n]) idx[n] <= 15'd0;
            else if (src_enable[n]) begin
                if (hang) idx[n] <= (idx[n] == 15'd19199) ? 15'd0 : idx[n] + 15'd1;
                else if (idx[n] != 15'd19200) idx[n] <= idx[n] + 15'd1;
            end
            col_q[n] <= 3'(pix_x(idx[n]) + 8'(pix_y(idx[n])));
        end
    end

    always_comb begin
        src_x = 24'd0; src_y = 21'd0; src_col = 9'd0; src_done = 3'd0;
        for (int n = 0; n < 3; n++) begin
            if (junk && n != 2) begin
                src_x[8*n +: 8]   = junk_r[7:0] ^ 8'(n);
                src_y[7*n +: 7]   = junk_r[14:8];
                src_col[3*n +: 3] = junk_r[17:15];
                src_done[n]       = junk_r[20 + n];
            end else begin
                src_x[8*n +: 8]   = pix_x(idx[n]);
                src_y[7*n +: 7]   = pix_y(idx[n]);
                src_col[3*n +: 3] = col_q[n];
                src_done[n]       = (!hang && idx[n] == 15'd19200) || (n == 0 && force_done0);
            end
        end
    end

    // Output monitor sampled on the falling edge
    always @(negedge clock) begin
        if (vga_plot === 1'b1) begin
            if (plot_cnt == 0) begin first_x = vga_x; first_y = vga_y; end
            last_x = vga_x; last_y = vga_y;
            if (int'(vga_x) != (exp_idx % 19200) % 160 || int'(vga_y) != (exp_idx % 19200) / 160 ||
                int'(vga_col) != (int'(vga_x) + int'(vga_y)) % 8)
                pix_err++;
            exp_idx++;
            plot_cnt++;
        end
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (src_enable !== 3'b000) en_cnt++;
    end

    initial begin
        #1_500_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic clear_mon();
        plot_cnt = 0; pix_err = 0; exp_idx = 0; done_cnt = 0;
        err_cnt = 0; busy_cnt = 0; en_cnt = 0;
        first_x = 8'd0; first_y = 7'd0; last_x = 8'd0; last_y = 7'd0;
    endtask

    task automatic do_req(input logic [1:0] scr);
        req = 1'b1;
        req_screen = scr;
        tick();
        req = 1'b0;
    endtask

    task automatic wait_pulse(input string tag, input bit want_err);
        int cyc;
        cyc = 0;
        while (((want_err ? err : done) !== 1'b1) && cyc < 25000) begin
            tick();
            cyc++;
        end
        check(tag, 32'(want_err ? err : done), 32'd1);
    endtask

    task automatic check_screen(input string tag);
        check({tag, "_plots"}, 32'(plot_cnt), 32'd19200);
        check({tag, "_pix_err"}, 32'(pix_err), 32'd0);
        check({tag, "_first"}, {16'd0, first_x, 1'b0, first_y}, 32'd0);
        check({tag, "_last"}, {16'd0, last_x, 1'b0, last_y}, {16'd0, 8'd159, 1'b0, 7'd119});
        check({tag, "_dones"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; req = 1'b0; req_screen = 2'd0;
        junk = 1'b0; hang = 1'b0; force_done0 = 1'b0;
        clear_mon();
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_plot", 32'(vga_plot), 32'd0);
        check("rst_xycol", {14'd0, vga_x, vga_y, vga_col}, 32'd0);
        check("rst_enable", 32'(src_enable), 32'd0);
        check("rst_clear_n", 32'(src_clear_n), 32'd0);
        reset_n = 1'b1;
        tick();
        check("idle_clear_n", 32'(src_clear_n), 32'b111);

        // Full victory screen
        clear_mon();
        do_req(2'd1);
        check("s1_clear_busy", 32'(busy), 32'd1);
        check("s1_clear_n", 32'(src_clear_n), 32'b101);
        tick();
        check("s1_enable", 32'(src_enable), 32'b010);
        wait_pulse("s1_done_seen", 1'b0);
        check("s1_fin_busy", 32'(busy), 32'd1);
        check("s1_fin_plot", 32'(vga_plot), 32'd0);
        tick();
        check("s1_busy_drop", {30'd0, busy, done}, 32'd0);
        check_screen("s1");
        check("s1_busy_span", 32'(busy_cnt), 32'd19204);

        // Death screen with unselected drawers toggling and a request during DRAW
        junk = 1'b1;
        clear_mon();
        do_req(2'd2);
        check("s2_clear_n", 32'(src_clear_n), 32'b011);
        tick();
        check("s2_clear_n_rel", 32'(src_clear_n), 32'b111);
        check("s2_enable", 32'(src_enable), 32'b100);
        repeat (100) tick();
        do_req(2'd0);
        check("s2_busy_req_enable", 32'(src_enable), 32'b100);
        wait_pulse("s2_done_seen", 1'b0);
        repeat (4) tick();
        check_screen("s2");
        check("s2_idle_busy", 32'(busy), 32'd0);
        junk = 1'b0;

        // Invalid screen code
        clear_mon();
        do_req(2'd3);
        repeat (5) tick();
        check("inv_busy_cycles", 32'(busy_cnt), 32'd0);
        check("inv_plots", 32'(plot_cnt), 32'd0);
        check("inv_enable", 32'(en_cnt), 32'd0);

        // Watchdog abort with a drawer that never finishes
        hang = 1'b1;
        clear_mon();
        do_req(2'd0);
        tick();
        wait_pulse("wd_err_seen", 1'b1);
        check("wd_draw_cycles", 32'(en_cnt), 32'd20000);
        check("wd_abort_plot", 32'(vga_plot), 32'd0);
        check("wd_abort_busy", 32'(busy), 32'd1);
        tick();
        check("wd_after_busy_err", {30'd0, busy, err}, 32'd0);
        check("wd_after_plot", 32'(vga_plot), 32'd0);
        check("wd_no_done", 32'(done_cnt), 32'd0);
        check("wd_err_count", 32'(err_cnt), 32'd1);
        hang = 1'b0;

        // Reset in the middle of a draw, then a clean full screen
        clear_mon();
        do_req(2'd1);
        for (int c = 0; c < 6000 && plot_cnt < 5000; c++) tick();
        check("mid_reached_5000", 32'(plot_cnt), 32'd5000);
        reset_n = 1'b0;
        tick();
        check("mid_rst_plot", 32'(vga_plot), 32'd0);
        check("mid_rst_enable", 32'(src_enable), 32'd0);
        check("mid_rst_clear_n", 32'(src_clear_n), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        clear_mon();
        do_req(2'd1);
        tick();
        wait_pulse("mid_redo_done_seen", 1'b0);
        tick();
        check_screen("mid_redo");

        // Stale drawer: done already high when DRAW starts
        force_done0 = 1'b1;
        clear_mon();
        do_req(2'd0);
        tick();
        check("stale_enable", 32'(src_enable), 32'b001);
        tick();
        check("stale_flush_done", 32'(done), 32'd0);
        tick();
        check("stale_fin_done", 32'(done), 32'd1);
        tick();
        force_done0 = 1'b0;
        check("stale_plots", 32'(plot_cnt), 32'd0);
        check("stale_dones", 32'(done_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/screen_draw_ctrl.md
Name: screen_draw_ctrl

Overview:
Sequencer and output mux between the three full-screen image drawers (splash, victory, death) and the VGA adapter write port. On a request it clears the selected drawer, enables it, and re-times its coordinate stream by one stage so each pixel's x/y lines up with its colour from the image RAM. It drives the adapter's x/y/colour/plot and reports completion to the game FSM with a busy/done handshake. It is the stage directly downstream of the drawers.

Parameters:
RAM_LATENCY, 1, image RAM read latency in cycles; x/y/valid delay depth (1..3)
MAX_CYCLES, 20000, watchdog limit on DRAW cycles before abort
SCREEN_PIXELS, 19200, 160x120 pixel count, informational width sizing only

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
req  in  1  draw request strobe, sampled in IDLE only
req_screen  in  2  0 splash, 1 victory, 2 death, 3 invalid
busy  out  1  high from accepted req until done/err pulse cycle inclusive
done  out  1  one-cycle pulse: screen completed
err  out  1  one-cycle pulse: watchdog abort
src_enable  out  3  one-hot drawer enable, bit n = screen n
src_clear_n  out  3  active-low synchronous clear to drawers
src_x  in  24  drawer x, 8 bits per drawer, drawer n at [8n+7:8n]
src_y  in  21  drawer y, 7 bits per drawer, drawer n at [7n+6:7n]
src_col  in  9  drawer colour, 3 bits per drawer, drawer n at [3n+2:3n]
src_done  in  3  drawer done flags
vga_x  out  8  pixel x
vga_y  out  7  pixel y
vga_col  out  3  pixel colour
vga_plot  out  1  adapter write enable

Behaviour:
- Reset: state IDLE; busy, done, err, vga_plot = 0; vga_x/y/col = 0; src_enable = 0; src_clear_n = 3'b000, so all drawers are cleared while reset is held. Delay pipe valid bits = 0. Watchdog = 0.
- Reset mid-draw: the same values apply on the next edge, and no plot occurs after the reset edge.
- IDLE: src_clear_n = 3'b111.
  - req=1 with req_screen<3: latch sel and go to CLEAR.
  - req_screen=3: ignored; busy stays 0.
- CLEAR (1 cycle): busy=1; src_clear_n[sel]=0, other bits 1; go to DRAW.
- DRAW: src_enable[sel]=1.
  - Each cycle, push {src_x[sel], src_y[sel], valid} into a RAM_LATENCY-deep shift pipe, where valid = ~src_done[sel].
  - Pipe output drives vga_x/vga_y; vga_col = src_col[sel] in the same cycle; vga_plot = pipe valid.
  - When src_done[sel]=1: deassert enable and go to FLUSH.
  - When the watchdog reaches MAX_CYCLES-1: go to ABORT.
- FLUSH (RAM_LATENCY cycles): pipe drains and remaining valid pixels plot; then go to FIN.
- FIN (1 cycle): done=1, busy=1; go to IDLE. busy drops the following cycle.
- ABORT (1 cycle): err=1, plot forced 0, pipe cleared, enable 0; go to IDLE.
- req while busy: ignored, not queued.
- Outside DRAW/FLUSH, vga_plot=0 and vga_x/y/col hold their last values.
- Watchdog: 15-bit counter, cleared in CLEAR, increments each DRAW cycle.
- src_done[sel] high on the first DRAW cycle (stale drawer): zero plots, then FLUSH and FIN. A done pulse is still issued.
- Unselected drawer inputs never affect outputs.

Decomposition:
- Shared package (draw_pkg): screen codes SCR_SPLASH=0, SCR_VICTORY=1, SCR_DEATH=2; X_W=8, Y_W=7, COL_W=3; SCREEN_W=160, SCREEN_H=120.
- One sub-module: coord_delay_pipe, a parameterised RAM_LATENCY-stage register pipe of {x, y, valid} with synchronous clear.
- FSM and mux stay in the top level.

Test Plan:
- Bench drawer model: raster x 0..159, y 0..119, col = (x+y)%8 returned one cycle late, done after 19200 pixels.
  - req_screen=1 -> exactly 19200 plots.
  - Each plot satisfies vga_col == (vga_x+vga_y)%8.
  - First plot is (0,0); last plot is (159,119).
  - One done pulse; busy spans CLEAR through FIN.
- Clear check: req_screen=2 -> src_clear_n=3'b011 for exactly 1 cycle, then src_enable=3'b100. Drawers 0 and 1 toggling their inputs cause no plot differences.
- Invalid and busy requests: req_screen=3 -> busy stays 0, no plots. req during DRAW -> ignored, still exactly 1 done.
- Watchdog: model never asserts done -> err pulse at DRAW cycle 20000, plot low afterward, busy low next cycle, no done pulse.
- Mid-draw reset: reset_n=0 at pixel 5000 -> next cycle plot=0, src_enable=0, src_clear_n=0. A new req after release yields a full 19200-pixel screen.
- Stale drawer: src_done[0]=1 when DRAW is entered -> 0 plots, done pulse 2 cycles after entering DRAW (RAM_LATENCY=1).
